// File: rtl/wb_regfile.sv
// wb_regfile -- write-back end of the MEM/WB pipeline interface.
//
// Chooses the write-back value (load data or ALU result) and commits it
// into a 2**ADDR_W entry general-purpose register file. The file serves
// two combinational read ports (rs/rt) to the ID stage. A free-running
// counter tracks retired register writes for debug and performance use.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - write-through bypass: a qualified write to the address
//               being read is returned on that read port in the same cycle.
//   undefined - read ports return the stored (pre-write) value; the hazard
//               unit has to stall one cycle for WB->ID dependencies.
//
// Ports
//   clk              in   1       rising-edge clock
//   rst_n            in   1       asynchronous active-low reset
//   wb_regwrite      in   1       MEM/WB RegWrite control
//   wb_memtoreg      in   1       1 = load data, 0 = ALU result
//   wb_read_data     in   DATA_W  MEM/WB load data
//   wb_alu_result    in   DATA_W  MEM/WB ALU result/address
//   wb_dest          in   ADDR_W  destination register index
//   rs_addr          in   ADDR_W  read port A index
//   rt_addr          in   ADDR_W  read port B index
//   rs_data          out  DATA_W  read port A data (combinational)
//   rt_data          out  DATA_W  read port B data (combinational)
//   wb_value         out  DATA_W  selected write-back value (combinational)
//   wb_commit_count  out  CNT_W   retired register-write counter (wraps)

module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_regwrite,
  input  logic              wb_memtoreg,
  input  logic [DATA_W-1:0] wb_read_data,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_value,
  output logic [CNT_W-1:0]  wb_commit_count
);

  localparam int DEPTH = 1 << ADDR_W;

  // Every entry must clear asynchronously and both read ports are
  // combinational, so the file is built from flops rather than block RAM.
  logic [DATA_W-1:0] regs_reg [DEPTH];
  logic [CNT_W-1:0]  commit_count_reg;
  logic              we;

  assign wb_value = wb_memtoreg ? wb_read_data : wb_alu_result;

  // Writes aimed at $0 are dropped and are not counted as retired writes.
  assign we = wb_regwrite && (wb_dest != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
      commit_count_reg <= '0;
    end else if (we) begin
      regs_reg[wb_dest] <= wb_value;
      commit_count_reg  <= commit_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign wb_commit_count = commit_count_reg;

  // Read ports. $0 is forced to zero at the port as well, so a stray value
  // in entry 0 can never leak out and the bypass can never target $0.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != '0) begin
      rs_data = regs_reg[rs_addr];
`ifdef REGFILE_BYPASS_EN
      if (we && (rs_addr == wb_dest)) begin
        rs_data = wb_value;
      end
`endif
    end
    if (rt_addr != '0) begin
      rt_data = regs_reg[rt_addr];
`ifdef REGFILE_BYPASS_EN
      if (we && (rt_addr == wb_dest)) begin
        rt_data = wb_value;
      end
`endif
    end
  end

endmodule
